// File: rtl/video_types_pkg.sv
// Shared video definitions: LCD mode encoding, register addresses,
// default dot/line timing and the STAT register layout.
package video_types;

  // Default timing backing the lcd_timing_gen parameters
  localparam int unsigned LCD_DOTS_PER_LINE = 456;
  localparam int unsigned LCD_VISIBLE_LINES = 144;
  localparam int unsigned LCD_TOTAL_LINES   = 154;
  localparam int unsigned LCD_OAM_DOTS      = 80;
  localparam int unsigned LCD_DRAW_DOTS     = 172;

  // Register port addresses
  localparam logic [15:0] STAT_ADDR = 16'hFF41;
  localparam logic [15:0] LY_ADDR   = 16'hFF44;
  localparam logic [15:0] LYC_ADDR  = 16'hFF45;

  typedef enum logic [1:0] {
    HBLANK   = 2'd0,
    VBLANK   = 2'd1,
    OAM_SCAN = 2'd2,
    DRAWING  = 2'd3
  } LcdMode;

  // STAT as seen on a read: bit 7 constant 1, enables, coincidence, mode
  typedef struct packed {
    logic       always_one;
    logic       en_lyc;
    logic       en_m2;
    logic       en_m1;
    logic       en_m0;
    logic       coin;
    logic [1:0] mode;
  } StatReg;

endpackage

// File: rtl/lcd_timing_gen_stat_irq.sv
// LY/LYC coincidence, STAT interrupt source OR and rising-edge detector.
module lcd_stat_irq
  import video_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_enable,
  input  logic [7:0] line,
  input  logic [7:0] lyc,
  input  LcdMode     mode,
  input  logic [3:0] enables,   // {lyc, mode2, mode1, mode0}
  output logic       coin,
  output logic       irq_stat
);

  logic stat_line;
  logic stat_line_q;

  assign coin = (line == lyc);

  // Combined STAT interrupt condition
  always_comb begin
    stat_line = (enables[3] & coin)
              | (enables[2] & (mode == OAM_SCAN))
              | (enables[1] & (mode == VBLANK))
              | (enables[0] & (mode == HBLANK));
  end

  // Previous condition; cleared while the display is off so re-enable starts clean
  always_ff @(posedge clk) begin
    if (reset || !lcd_enable) begin
      stat_line_q <= 1'b0;
    end else begin
      stat_line_q <= stat_line;
    end
  end

  // Only a low-to-high transition requests an interrupt (STAT blocking)
  assign irq_stat = lcd_enable & ~reset & stat_line & ~stat_line_q;

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD dot/line timing generator with STAT, LY and LYC registers.
module lcd_timing_gen
  import video_types::*;
#(
  parameter int unsigned DOTS_PER_LINE = LCD_DOTS_PER_LINE,
  parameter int unsigned VISIBLE_LINES = LCD_VISIBLE_LINES,
  parameter int unsigned TOTAL_LINES   = LCD_TOTAL_LINES,
  parameter int unsigned OAM_DOTS      = LCD_OAM_DOTS,
  parameter int unsigned DRAW_DOTS     = LCD_DRAW_DOTS,
  parameter logic [15:0] STAT_ADDR     = video_types::STAT_ADDR,
  parameter logic [15:0] LY_ADDR       = video_types::LY_ADDR,
  parameter logic [15:0] LYC_ADDR      = video_types::LYC_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lcd_enable,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  reg_wdata,
  input  logic        reg_we,
  input  logic        reg_re,
  output logic [7:0]  reg_rdata,
  output logic        reg_hit,
  output logic [7:0]  ly,
  output logic [1:0]  mode,
  output logic        drawline,
  output logic        frame_start,
  output logic        irq_vblank,
  output logic        irq_stat,
  output logic        oam_locked,
  output logic        vram_locked
);

  localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
  localparam logic [7:0] LINE_LAST = 8'(TOTAL_LINES - 1);
  localparam logic [7:0] VIS_LINES = 8'(VISIBLE_LINES);
  localparam logic [8:0] OAM_END   = 9'(OAM_DOTS);
  localparam logic [8:0] DRAW_END  = 9'(OAM_DOTS + DRAW_DOTS);

  logic [8:0] dot;
  logic [7:0] line;
  logic [7:0] lyc;
  logic [3:0] stat_en;
  LcdMode     cur_mode;
  logic       coin;
  logic       pulse_ok;
  StatReg     stat_view;
  logic       rd_hit;
  logic [7:0] rd_val;
  logic       unused_wdata_bits;

  assign unused_wdata_bits = ^{reg_wdata[7], reg_wdata[2:0]};

  // Dot and line counters; held at the frame origin while the display is off
  always_ff @(posedge clk) begin
    if (reset || !lcd_enable) begin
      dot  <= '0;
      line <= '0;
    end else if (dot == DOT_LAST) begin
      dot  <= '0;
      line <= (line == LINE_LAST) ? '0 : line + 8'd1;
    end else begin
      dot <= dot + 9'd1;
    end
  end

  // Mode decode from the registered counters
  always_comb begin
    cur_mode = HBLANK;
    if (lcd_enable) begin
      if (line >= VIS_LINES)    cur_mode = VBLANK;
      else if (dot < OAM_END)   cur_mode = OAM_SCAN;
      else if (dot < DRAW_END)  cur_mode = DRAWING;
      else                      cur_mode = HBLANK;
    end
  end

  // Pulses are suppressed during reset so the reset cycle never leaks a strobe
  assign pulse_ok    = lcd_enable & ~reset;
  assign ly          = line;
  assign mode        = cur_mode;
  assign drawline    = pulse_ok & (line < VIS_LINES) & (dot == OAM_END);
  assign frame_start = pulse_ok & (line == 8'd0) & (dot == 9'd0);
  assign irq_vblank  = pulse_ok & (line == VIS_LINES) & (dot == 9'd0);
  assign oam_locked  = (cur_mode == OAM_SCAN) | (cur_mode == DRAWING);
  assign vram_locked = (cur_mode == DRAWING);

  lcd_stat_irq u_stat_irq (
    .clk        (clk),
    .reset      (reset),
    .lcd_enable (lcd_enable),
    .line       (line),
    .lyc        (lyc),
    .mode       (cur_mode),
    .enables    (stat_en),
    .coin       (coin),
    .irq_stat   (irq_stat)
  );

  // Read decode of the current (pre-write) register contents
  always_comb begin
    stat_view.always_one = 1'b1;
    stat_view.en_lyc     = stat_en[3];
    stat_view.en_m2      = stat_en[2];
    stat_view.en_m1      = stat_en[1];
    stat_view.en_m0      = stat_en[0];
    stat_view.coin       = coin;
    stat_view.mode       = cur_mode;
    rd_hit = 1'b1;
    rd_val = '0;
    case (reg_addr)
      STAT_ADDR: rd_val = stat_view;
      LY_ADDR:   rd_val = line;
      LYC_ADDR:  rd_val = lyc;
      default:   rd_hit = 1'b0;
    endcase
  end

  // Register writes and registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_en   <= '0;
      lyc       <= '0;
      reg_rdata <= '0;
      reg_hit   <= 1'b0;
    end else begin
      if (reg_we) begin
        if (reg_addr == STAT_ADDR) stat_en <= reg_wdata[6:3];
        if (reg_addr == LYC_ADDR)  lyc     <= reg_wdata;
      end
      reg_hit   <= reg_re & rd_hit;
      reg_rdata <= reg_re ? rd_val : '0;
    end
  end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
Dot-clock timing generator that sits directly upstream of the line renderer. It owns the per-dot and per-line counters and derives the LCD mode (OAM scan, drawing, HBlank, VBlank). It produces the per-line `drawline` strobe that triggers rendering, plus the VBlank and STAT interrupt requests. It also implements the STAT (FF41), LY (FF44) and LYC (FF45) registers on a simple register port.

Parameters:
DOTS_PER_LINE, 456, clocks per scanline
VISIBLE_LINES, 144, rendered lines; line 144 is the first VBlank line
TOTAL_LINES, 154, lines per frame including VBlank
OAM_DOTS, 80, length of mode 2 at the start of each visible line
DRAW_DOTS, 172, length of mode 3, following mode 2
STAT_ADDR, 16'hFF41, STAT register address
LY_ADDR, 16'hFF44, LY register address
LYC_ADDR, 16'hFF45, LYC register address

Ports:
clk  in  1  system clock; one dot per cycle
reset  in  1  synchronous, active-high reset
lcd_enable  in  1  LCDC bit 7; display on/off
reg_addr  in  16  register port address
reg_wdata  in  8  register write data
reg_we  in  1  register write strobe, one cycle
reg_re  in  1  register read strobe, one cycle
reg_rdata  out  8  read data, valid the cycle after reg_re
reg_hit  out  1  high with reg_rdata when the read address decoded to this block
ly  out  8  current line, 0..153
mode  out  2  0=HBlank, 1=VBlank, 2=OAM scan, 3=drawing
drawline  out  1  one-cycle pulse at the first dot of mode 3 on each visible line
frame_start  out  1  one-cycle pulse at line 0, dot 0
irq_vblank  out  1  one-cycle VBlank interrupt request
irq_stat  out  1  one-cycle STAT interrupt request
oam_locked  out  1  high in modes 2 and 3
vram_locked  out  1  high in mode 3

Behaviour:
- Reset: dot=0, line=0, LYC=0, STAT enable bits=0, stat_line_q=0. All pulse outputs, reg_rdata and reg_hit are 0. mode=2 if lcd_enable is high, otherwise 0.
- Counters:
  - dot increments every cycle while lcd_enable=1 and wraps at DOTS_PER_LINE-1 to 0.
  - On a dot wrap, line increments and wraps at TOTAL_LINES-1 to 0.
  - Counter widths are 9 bits (dot) and 8 bits (line).
- Mode is combinational from the registered counters:
  - line>=VISIBLE_LINES: mode 1.
  - otherwise dot<OAM_DOTS: mode 2.
  - otherwise dot<OAM_DOTS+DRAW_DOTS: mode 3.
  - otherwise mode 0.
- ly equals line.
- drawline: asserted for exactly the single cycle where line<VISIBLE_LINES and dot==OAM_DOTS. This gives 144 pulses per frame, spaced DOTS_PER_LINE apart.
- frame_start: asserted when line==0 and dot==0 with lcd_enable=1.
- irq_vblank: asserted for one cycle when line==VISIBLE_LINES and dot==0.
- Coincidence flag: coin = (line==LYC), evaluated every cycle.
- STAT interrupt source: stat_line = (en_lyc & coin) | (en_m2 & mode==2) | (en_m1 & mode==1) | (en_m0 & mode==0).
  - irq_stat = stat_line & ~stat_line_q, a rising-edge pulse.
  - Back-to-back qualifying sources with no low gap produce no second pulse (STAT blocking).
- lcd_enable low:
  - dot and line are forced to 0 on the next clock; mode=0; ly=0.
  - drawline, frame_start, irq_vblank and irq_stat are held 0; stat_line_q is cleared; locks are deasserted.
  - Registers remain readable and writable.
- lcd_enable rising: the first enabled cycle is line 0, dot 0, mode 2, with a frame_start pulse. No irq_vblank occurs until line 144 is reached.
- STAT register:
  - Bit 7 reads 1.
  - Bits 6..3 are R/W enables: LYC, mode2, mode1, mode0.
  - Bit 2 is coin (read-only); bits 1..0 are mode (read-only). Writes to bits 2..0 are ignored.
- LY register: read-only; writes are ignored.
- LYC register: R/W. A written value affects coin starting the cycle after the write.
- Register reads:
  - reg_rdata and reg_hit are registered, with 1-cycle latency.
  - An unmatched address gives reg_hit=0 and reg_rdata=0.
  - reg_we and reg_re in the same cycle: the write takes effect and the read returns the pre-write value.
- Reset mid-frame: the reset state applies on the next edge and overrides all other activity, including a pending pulse in the same cycle.

Decomposition:
- Shared package video_types gains:
  - an LcdMode enum (HBLANK=0, VBLANK=1, OAM_SCAN=2, DRAWING=3);
  - the STAT_ADDR, LY_ADDR and LYC_ADDR constants;
  - the timing constants backing the parameter defaults;
  - a packed StatReg struct.
- One sub-module, lcd_stat_irq, holds the coincidence compare, the stat_line OR and the edge detector. The counters and register decode stay in the top.

Test Plan:
- Reset, then lcd_enable=1 for 70224 cycles:
  - exactly 144 drawline pulses, the first at cycle 80 and the last at cycle 143*456+80;
  - one irq_vblank at cycle 65664;
  - one frame_start at cycle 0 and another at cycle 70224.
- Mode sequence on line 5: dots 0–79 give mode 2, dots 80–251 mode 3, dots 252–455 mode 0; oam_locked and vram_locked track the modes.
- Write LYC=0x0A and STAT=0x40 → one irq_stat when line 10 begins; a STAT read in that line returns 0xC6 (mode 2) then 0xC7 (mode 3).
- Write STAT=0x18 (mode0+mode1 enables) → one irq_stat per HBlank on lines 0–143. Across the line-143 HBlank into VBlank the condition stays continuous, so no extra pulse occurs at line 144.
- Drop lcd_enable at line 50, dot 200 → the next cycle shows ly=0, mode=0 and no pulses. Re-enable → frame_start pulses immediately and drawline pulses 80 cycles later.
- Write 0x55 to LY → a read returns the live line, not 0x55. A read of 0xFF40 → reg_hit=0 and rdata=0. Same-cycle write and read of LYC → the read returns the old value.
